pipe_adder: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor built from the team's full-adder cell. It generalises the single-bit full adder to WIDTH bits, split into STAGES carry-chained slices with one register stage per slice. Operands enter with a valid/ready handshake. Results leave after a fixed latency with carry, signed overflow, and global backpressure. It sits in the datapath wherever a wide add must close timing at high clock rates.

---
 rtl/pipe_adder.sv | 97 +++++++++
 tb/tb_pipe_adder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined ripple-carry adder/subtractor with valid/ready handshake
// Each slice adds WIDTH/STAGES bits; its carry feeds the next slice one stage later.
module pipe_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int S = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub ? ~cin : cin;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO = k * S;
    localparam int SW = WIDTH - LO;

    // src_a/src_b hold only the operand bits this slice and later slices still need
    logic [SW-1:0]   src_a;
    logic [SW-1:0]   src_b;
    logic            src_c;
    logic            src_v;
    logic [S:0]      slice;
    logic [LO+S-1:0] nxt_s;

    assign slice = {1'b0, src_a[S-1:0]} + {1'b0, src_b[S-1:0]} + {{S{1'b0}}, src_c};

    if (k == 0) begin : first
      assign src_a = a;
      assign src_b = b_eff;
      assign src_c = c0;
      assign src_v = in_valid;
      assign nxt_s = slice[S-1:0];
    end else begin : chain
      assign src_a = stg[k-1].mid.a_r;
      assign src_b = stg[k-1].mid.b_r;
      assign src_c = stg[k-1].mid.c_r;
      assign src_v = stg[k-1].mid.v_r;
      assign nxt_s = {slice[S-1:0], stg[k-1].mid.s_r};
    end

    if (k < STAGES - 1) begin : mid
      logic            v_r;
      logic            c_r;
      logic [LO+S-1:0] s_r;
      logic [SW-S-1:0] a_r;
      logic [SW-S-1:0] b_r;

      always_ff @(posedge clk) begin
        if (rst) begin
          v_r <= 1'b0;
        end else if (adv) begin
          v_r <= src_v;
          c_r <= slice[S];
          s_r <= nxt_s;
          a_r <= src_a[SW-1:S];
          b_r <= src_b[SW-1:S];
        end
      end
    end else begin : last
      // Operand MSBs are the top bits of this slice, so overflow is resolved here
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid <= 1'b0;
          sum       <= '0;
          carry     <= 1'b0;
          overflow  <= 1'b0;
        end else if (adv) begin
          out_valid <= src_v;
          sum       <= nxt_s;
          carry     <= slice[S];
          overflow  <= (src_a[SW-1] == src_b[SW-1]) & (nxt_s[WIDTH-1] != src_a[SW-1]);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - self-checking bench for pipe_adder (WIDTH=8, STAGES=4)
module tb_pipe_adder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       carry;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nout = 0;
  int n_acc = 0;
  int first_out = -1;
  int last_out = -1;
  logic [31:0] exp_q[$];

  pipe_adder #(.WIDTH(8), .STAGES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] res();
    return {22'b0, carry, overflow, sum};
  endfunction

  // Integer reference: unsigned range gives carry, signed range gives overflow
  function automatic logic [31:0] model(input logic [7:0] ta, input logic [7:0] tb,
                                        input logic tc, input logic ts);
    int r;
    int sr;
    logic [7:0] s;
    logic c;
    logic o;
    if (!ts) begin
      r  = int'(ta) + int'(tb) + int'(tc);
      sr = int'($signed(ta)) + int'($signed(tb)) + int'(tc);
      c  = (r > 255);
    end else begin
      r  = int'(ta) - int'(tb) - int'(tc);
      sr = int'($signed(ta)) - int'($signed(tb)) - int'(tc);
      c  = (r >= 0);
    end
    s = r[7:0];
    o = (sr > 127) || (sr < -128);
    return {22'b0, c, o, s};
  endfunction

  task automatic send_one(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          input logic ts, input logic [31:0] exp, input string tag);
    int lat;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, 4);
    check(tag, res(), exp);
    @(posedge clk); #1;
  endtask

  task automatic tick();
    #1;
    if (in_valid && in_ready) begin
      exp_q.push_back(model(a, b, cin, sub));
      n_acc++;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'd1, 32'd0);
      end else begin
        check("stream_out", res(), exp_q.pop_front());
        nout++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic rand_ops();
    a = 8'($urandom);
    b = 8'($urandom);
    cin = ($urandom_range(0, 1) == 1);
    sub = ($urandom_range(0, 1) == 1);
  endtask

  initial begin
    int c0;
    int acc;
    rst = 1'b1; in_valid = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_outs", res(), 32'd0);
    check("rst_ready", {31'b0, in_ready}, 32'd1);

    send_one(8'hFF, 8'h01, 1'b0, 1'b0, 32'h200, "wrap");
    send_one(8'h7F, 8'h01, 1'b0, 1'b0, 32'h180, "sovf");
    send_one(8'h10, 8'h20, 1'b1, 1'b0, 32'h031, "cin");
    send_one(8'h05, 8'h07, 1'b0, 1'b1, 32'h0FE, "sub_neg");
    send_one(8'h80, 8'h01, 1'b0, 1'b1, 32'h37F, "sub_ovf");
    send_one(8'h09, 8'h04, 1'b1, 1'b1, 32'h204, "sub_bin");

    // Back-to-back streaming
    nout = 0; first_out = -1; last_out = -1; c0 = cyc;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rand_ops();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
    check("stream_cnt", nout, 16);
    check("stream_first", first_out - c0, 4);
    check("stream_last", last_out - c0, 19);

    // Fill then stall for 5 cycles
    out_ready = 1'b0; acc = 0;
    for (int k = 0; k < 10; k++) begin
      rand_ops();
      in_valid = 1'b1;
      #1;
      if (!in_ready) break;
      acc++;
      tick();
    end
    check("fill_cnt", acc, 4);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_ready", {31'b0, in_ready}, 32'd0);
      check("stall_valid", {31'b0, out_valid}, 32'd1);
      check("stall_hold", res(), (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD);
    end
    in_valid = 1'b0; out_ready = 1'b1; nout = 0;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
    check("drain_empty", exp_q.size(), 0);
    check("drain_cnt", nout, 4);

    // Random valid/ready over 1000 beats
    nout = 0; n_acc = 0;
    for (int t = 0; t < 8000 && n_acc < 1000; t++) begin
      rand_ops();
      in_valid = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    check("rand_acc", n_acc, 1000);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
    check("rand_empty", exp_q.size(), 0);
    check("rand_cnt", nout, n_acc);

    // Reset with 3 beats in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      in_valid = 1'b1;
      tick();
    end
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_outs", res(), 32'd0);
    nout = 0;
    repeat (8) tick();
    check("mid_rst_ghost", nout, 0);
    send_one(8'h3C, 8'h4A, 1'b0, 1'b0, 32'h186, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
